layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Controller for one fully-connected layer of `Neuron_*` instances. It buffers an input activation vector arriving from the previous layer, then broadcasts that vector to every neuron in the layer as one contiguous burst. It collects each neuron's result on its `outvalid` and streams the result vector to the next layer over a valid/ready handshake. One instance sits between consecutive layers in the FNN accelerator.

## Interface
- `numInputs`, 10: activations per inference; equals every neuron's `numWeight`.
- `numNeurons`, 10: neurons in this layer.
- `dataWidth`, 16: activation width in bits.
- `timeoutCycles`, 1024: WAIT watchdog limit. Used only when `LAYER_SEQ_TIMEOUT_EN` is defined.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `in_data`  in  dataWidth: activation from the previous layer.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block accepts input; high only in FILL.
- `nrn_input`  out  dataWidth: broadcast activation, wired to every neuron's `myinput`.
- `nrn_input_valid`  out  1: broadcast valid, wired to every neuron's `myinputValid`.
- `nrn_out`  in  numNeurons*dataWidth: neuron outputs; neuron i drives slice `[i*dataWidth +: dataWidth]`.
- `nrn_valid`  in  numNeurons: per-neuron `outvalid`.
- `out_data`  out  dataWidth: result element to the next layer.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: the next layer accepts `out_data`.
- `busy`  out  1: state is not FILL, or at least one word is held in the input buffer.
- `err`  out  1: sticky watchdog flag.

## Operation
- FSM states: FILL → BCAST → WAIT → DRAIN → FILL.
- **FILL**
  - `in_ready`=1.
  - Each handshake writes `ibuf[wr_idx]` and increments `wr_idx`.
  - The handshake that accepts word `numInputs-1` moves the FSM to BCAST.
- **BCAST**
  - `nrn_input_valid`=1 for exactly `numInputs` consecutive cycles, with `nrn_input`=`ibuf[0..numInputs-1]` in order.
  - No gaps are allowed. Both outputs are registered.
  - The FSM then moves to WAIT, and the captured mask clears.
- **WAIT**
  - When `nrn_valid[i]`=1 and `cap[i]`=0, the block stores slice i into `obuf[i]` and sets `cap[i]`.
  - A repeat `nrn_valid[i]` after `cap[i]` is set is ignored; the first value is kept.
  - `nrn_valid` is ignored in every state other than WAIT.
  - When all bits of `cap` are set, the FSM moves to DRAIN on the next cycle.
- **DRAIN**
  - `out_valid`=1 with `out_data`=`obuf[rd_idx]`.
  - On each `out_valid & out_ready`, `rd_idx` increments.
  - `out_data` and `out_valid` hold stable while `out_ready`=0.
  - After the handshake on element `numNeurons-1`, the FSM returns to FILL and `wr_idx` and `rd_idx` clear.
- Indices wrap only through the explicit clear. Width of each index is `$clog2(n+1)`.
- No arithmetic is performed on data; values pass through unmodified.

## Timing
- Reset values:
  - FSM = FILL.
  - `in_ready`=1 from the first clock edge after deassertion.
  - `nrn_input`=0, `nrn_input_valid`=0, `out_valid`=0, `out_data`=0, `busy`=0, `err`=0.
  - `cap`, indices and buffers all =0.
- Reset asserted mid-operation aborts immediately:
  - all state returns to reset values;
  - a partial input vector is discarded;
  - no further `nrn_input_valid` is driven.
- Latencies:
  - Last FILL handshake at cycle t → first `nrn_input_valid` at t+1; last at t+numInputs.
  - Last `cap` bit set at cycle u → `out_valid` at u+1.
- `in_data` is not accepted during BCAST, WAIT or DRAIN.
- If the last `nrn_valid` arrives in the same cycle as other `nrn_valid` bits, all of them are captured.

## Configuration
- `LAYER_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `cap` is not all-ones after `timeoutCycles` cycles, `err` is set (sticky until reset) and the FSM enters DRAIN.
  - Uncaptured `obuf` entries are driven as 0.
- `LAYER_SEQ_TIMEOUT_EN` undefined:
  - No counter exists; WAIT holds indefinitely.
  - `err` is tied to 0.

## Structure
- Package `layer_seq_pkg` holds:
  - the state enum `layer_seq_state_t` (FILL, BCAST, WAIT, DRAIN);
  - helper width functions.
- Sub-module `layer_seq_buf`: parameterised register file with depth, width, one write port, one async read port, and clear.
  - One instance is used as `ibuf`; one as `obuf`.

## Test plan
- Reset, then 10 inputs 1..10 with `in_valid` held high → `nrn_input_valid` high for exactly 10 cycles starting 1 cycle after the 10th handshake, with `nrn_input` sequence 1..10.
- Neuron models return 0x0100+i at staggered cycles in WAIT → DRAIN outputs 0x0100..0x0109 in neuron order; `out_valid` rises 1 cycle after the last capture.
- `out_ready` toggled 0/1 every cycle during DRAIN → `out_data` stable while stalled; exactly 10 transfers, then `in_ready`=1.
- Duplicate `nrn_valid[3]` with value 0xBEEF after its first capture of 0x0103, plus a spurious `nrn_valid` in FILL → DRAIN element 3 = 0x0103; FILL is unaffected.
- `rst` asserted during BCAST at the 5th word → `nrn_input_valid`=0 immediately; FSM is in FILL; a fresh 10-word vector then broadcasts correctly.
- With `LAYER_SEQ_TIMEOUT_EN`, `timeoutCycles`=32, neuron 7 never valid → `err`=1 at cycle 32 of WAIT; DRAIN element 7 = 0; all others are correct.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types and width helpers for the layer sequencer slice.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        FILL,
        BCAST,
        WAIT,
        DRAIN
    } layer_seq_state_t;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an address into an n-entry array (at least one bit).
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Input stream, neuron broadcast/collect and output stream of one layer_sequencer.
interface layer_sequencer_if #(
    parameter int dataWidth  = 16,
    parameter int numNeurons = 10
);

    logic [dataWidth-1:0]            in_data;
    logic                            in_valid;
    logic                            in_ready;
    logic [dataWidth-1:0]            nrn_input;
    logic                            nrn_input_valid;
    logic [numNeurons*dataWidth-1:0] nrn_out;
    logic [numNeurons-1:0]           nrn_valid;
    logic [dataWidth-1:0]            out_data;
    logic                            out_valid;
    logic                            out_ready;

    modport slave (
        input  in_data, in_valid, nrn_out, nrn_valid, out_ready,
        output in_ready, nrn_input, nrn_input_valid, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, nrn_out, nrn_valid, out_ready,
        input  in_ready, nrn_input, nrn_input_valid, out_data, out_valid
    );

endinterface

// File: rtl/layer_seq_buf.sv
// Register file with per-entry write enables over a parallel write port,
// one asynchronous read port and a synchronous clear.
module layer_seq_buf
    import layer_seq_pkg::*;
#(
    parameter int depth = 10,
    parameter int width = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [depth-1:0]              wr_en,
    input  logic [depth*width-1:0]        wr_data,
    input  logic [addr_width(depth)-1:0]  rd_addr,
    output logic [width-1:0]              rd_data
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < depth; i++) begin
                if (wr_en[i]) begin
                    mem[i] <= wr_data[i*width +: width];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < depth) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Buffers an activation vector, broadcasts it to a neuron layer and streams the results out.
// Optional WAIT watchdog: define LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int numInputs     = 10,
    parameter int numNeurons    = 10,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 1024
) (
    input  logic             clk,
    input  logic             rst,
    layer_sequencer_if.slave bus,
    output logic             busy,
    output logic             err
);

    localparam int WI_W = idx_width(numInputs);
    localparam int RI_W = idx_width(numNeurons);
    localparam int IA_W = addr_width(numInputs);
    localparam int OA_W = addr_width(numNeurons);

    if (numInputs < 1 || numNeurons < 1 || dataWidth < 1 || timeoutCycles < 1) begin : g_bad_params
        $error("layer_sequencer: size parameters must be positive");
    end

    layer_seq_state_t state, state_nxt;

    logic [WI_W-1:0]       wr_idx;
    logic [WI_W-1:0]       bc_idx;
    logic [RI_W-1:0]       rd_idx;
    logic [numNeurons-1:0] cap;
    logic [numNeurons-1:0] cap_nxt;
    logic [numNeurons-1:0] capture;
    logic [numInputs-1:0]  ibuf_we;
    logic [dataWidth-1:0]  ibuf_rdata;
    logic [dataWidth-1:0]  obuf_rdata;
    logic [dataWidth-1:0]  nrn_input_q;
    logic                  nrn_input_valid_q;
    logic                  in_ready_q;

    logic in_hs, last_in, bc_more, bc_done, all_cap, out_hs, last_out, wd_expire;

    always_comb begin
        in_hs    = in_ready_q && bus.in_valid;
        last_in  = in_hs && (wr_idx == WI_W'(numInputs - 1));
        bc_more  = (bc_idx < WI_W'(numInputs));
        bc_done  = (state == BCAST) && !bc_more;
        capture  = (state == WAIT) ? (bus.nrn_valid & ~cap) : '0;
        cap_nxt  = cap | capture;
        all_cap  = &cap_nxt;
        out_hs   = (state == DRAIN) && bus.out_ready;
        last_out = out_hs && (rd_idx == RI_W'(numNeurons - 1));
        for (int unsigned i = 0; i < numInputs; i++) begin
            ibuf_we[i] = in_hs && (wr_idx == WI_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:  if (last_in)               state_nxt = BCAST;
            BCAST: if (!bc_more)              state_nxt = WAIT;
            WAIT:  if (all_cap || wd_expire)  state_nxt = DRAIN;
            DRAIN: if (last_out)              state_nxt = FILL;
            default:                          state_nxt = FILL;
        endcase
    end

    // The first broadcast word is registered on the accepting edge so the
    // burst starts one cycle after the last input handshake; bc_idx then
    // points at the next word to load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx            <= '0;
            bc_idx            <= '0;
            rd_idx            <= '0;
            cap               <= '0;
            nrn_input_q       <= '0;
            nrn_input_valid_q <= 1'b0;
            in_ready_q        <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == FILL);

            if (last_out) begin
                wr_idx <= '0;
                rd_idx <= '0;
            end else begin
                if (in_hs)  wr_idx <= wr_idx + WI_W'(1);
                if (out_hs) rd_idx <= rd_idx + RI_W'(1);
            end

            if (last_in) begin
                nrn_input_valid_q <= 1'b1;
                nrn_input_q       <= (numInputs == 1) ? bus.in_data : ibuf_rdata;
                bc_idx            <= WI_W'(1);
            end else if ((state == BCAST) && bc_more) begin
                nrn_input_valid_q <= 1'b1;
                nrn_input_q       <= ibuf_rdata;
                bc_idx            <= bc_idx + WI_W'(1);
            end else begin
                nrn_input_valid_q <= 1'b0;
                nrn_input_q       <= '0;
                if (bc_done) bc_idx <= '0;
            end

            cap <= bc_done ? '0 : cap_nxt;
        end
    end

    layer_seq_buf #(
        .depth (numInputs),
        .width (dataWidth)
    ) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .clr     (last_out),
        .wr_en   (ibuf_we),
        .wr_data ({numInputs{bus.in_data}}),
        .rd_addr (IA_W'(bc_idx)),
        .rd_data (ibuf_rdata)
    );

    // Cleared on WAIT entry so any neuron that never reports reads back as zero.
    layer_seq_buf #(
        .depth (numNeurons),
        .width (dataWidth)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .clr     (bc_done),
        .wr_en   (capture),
        .wr_data (bus.nrn_out),
        .rd_addr (OA_W'(rd_idx)),
        .rd_data (obuf_rdata)
    );

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int WD_W = idx_width(timeoutCycles);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign wd_expire = (state == WAIT) && !all_cap && (wd_cnt == WD_W'(timeoutCycles - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + WD_W'(1) : '0;
            if (wd_expire) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    assign bus.in_ready        = in_ready_q;
    assign bus.nrn_input       = nrn_input_q;
    assign bus.nrn_input_valid = nrn_input_valid_q;
    assign bus.out_valid       = (state == DRAIN);
    assign bus.out_data        = (state == DRAIN) ? obuf_rdata : '0;
    assign busy                = (state != FILL) || (wr_idx != '0);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer; define LAYER_SEQ_TIMEOUT_EN to add the watchdog case.
module tb_layer_sequencer;

    localparam int NI = 10;
    localparam int NN = 10;
    localparam int DW = 16;
`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int TO = 32;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_out [NN];
    int d_stag [NN] = '{2, 0, 5, 1, 3, 4, 1, 6, 2, 6};
    int d_same [NN] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    layer_sequencer_if #(.dataWidth(DW), .numNeurons(NN)) bus ();

    layer_sequencer #(
        .numInputs     (NI),
        .numNeurons    (NN),
        .dataWidth     (DW),
        .timeoutCycles (TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [DW-1:0] base, input bit spurious);
        for (int k = 0; k < NI; k++) begin
            bus.in_data  = base + DW'(k);
            bus.in_valid = 1'b1;
            if (spurious) begin
                bus.nrn_valid = '1;
                bus.nrn_out   = {NN{16'hDEAD}};
            end
            check("fill_ready", bus.in_ready, 1);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.nrn_valid = '0;
    endtask

    task automatic check_bcast(input logic [DW-1:0] base);
        for (int c = 0; c < NI; c++) begin
            check("bcast_valid", bus.nrn_input_valid, 1);
            check($sformatf("bcast_data%0d", c), bus.nrn_input, base + DW'(c));
            if (c == 0) check("bcast_no_ready", bus.in_ready, 0);
            step();
        end
        check("bcast_end", bus.nrn_input_valid, 0);
        check("wait_busy", busy, 1);
    endtask

    // skip >= 0 leaves that neuron silent and waits out the watchdog instead.
    task automatic run_wait(input int dly [NN], input int skip, input int dup);
        int last = 0;
        for (int i = 0; i < NN; i++) if (i != skip && dly[i] > last) last = dly[i];
        if (skip >= 0) last = TO - 1;
        for (int cyc = 0; cyc <= last; cyc++) begin
            for (int i = 0; i < NN; i++) begin
                bus.nrn_valid[i]          = (i != skip) && (dly[i] == cyc);
                bus.nrn_out[i*DW +: DW]   = 16'h0100 + DW'(i);
            end
            if (dup >= 0 && cyc == dly[dup] + 1) begin
                bus.nrn_valid[dup]        = 1'b1;
                bus.nrn_out[dup*DW +: DW] = 16'hBEEF;
            end
            if (cyc == last) begin
                check("wait_hold", bus.out_valid, 0);
                if (skip >= 0) check("err_before_expiry", err, 0);
            end
            step();
        end
        bus.nrn_valid = '0;
        check("drain_rise", bus.out_valid, 1);
        if (skip >= 0) check("err_set", err, 1);
    endtask

    task automatic drain(input bit toggle);
        int idx = 0;
        for (int cyc = 0; cyc < 4 * NN && idx < NN; cyc++) begin
            bus.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            check("drain_valid", bus.out_valid, 1);
            check($sformatf("drain_data%0d", idx), bus.out_data, exp_out[idx]);
            if (bus.out_ready) idx++;
            step();
        end
        bus.out_ready = 1'b0;
        check("drain_count", idx, NN);
        check("drain_done", bus.out_valid, 0);
        check("back_to_fill", bus.in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.nrn_out   = '0;
        bus.nrn_valid = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NN; i++) exp_out[i] = 16'h0100 + DW'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_nrn_valid", bus.nrn_input_valid, 0);
        check("rst_nrn_input", bus.nrn_input, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        step();
        check("rst_in_ready", bus.in_ready, 1);

        // Inference 1: staggered neurons, neurons 7 and 9 finish together.
        send_vec(16'h0001, 1'b0);
        check_bcast(16'h0001);
        run_wait(d_stag, -1, -1);
        drain(1'b0);

        // Inference 2: spurious nrn_valid in FILL, duplicate neuron 3, stalled drain.
        send_vec(16'h0011, 1'b1);
        check_bcast(16'h0011);
        run_wait(d_stag, -1, 3);
        drain(1'b1);

        // Reset while the 5th word is on the broadcast bus.
        send_vec(16'h0021, 1'b0);
        repeat (4) step();
        check("bcast_5th", bus.nrn_input, 16'h0025);
        #2 rst = 1'b0;
        #1;
        check("abort_valid", bus.nrn_input_valid, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step();
        check("abort_ready", bus.in_ready, 1);
        check("abort_quiet", bus.nrn_input_valid, 0);
        send_vec(16'h0041, 1'b0);
        check_bcast(16'h0041);
        run_wait(d_same, -1, -1);
        drain(1'b0);

`ifdef LAYER_SEQ_TIMEOUT_EN
        exp_out[7] = '0;
        send_vec(16'h0051, 1'b0);
        check_bcast(16'h0051);
        run_wait(d_stag, 7, -1);
        drain(1'b0);
        check("err_sticky", err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
